// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage of a small 16-bit pipeline.
//
// Purpose
//   Holds the 16 x 16-bit register file and reads both source operands
//   combinationally. A write landing in the same cycle is bypassed through
//   to the read ports. The stage decodes the opcode into the wb/mem/ex
//   control bits, builds the zero- and sign-extended immediates, and detects
//   load-use hazards against a load sitting in EX.
//
// Handshake semantics
//   instrValid=0 or flush=1 turns the slot into a bubble (wb/mem/ex = 0)
//   and never stalls. A bubble is also produced on a load-use hazard, but
//   then stall=1 so that IF/ID and the PC hold the instruction for a retry.
//   flush wins over a hazard because the instruction is being killed anyway.
//
// Configuration
//   ID_STALL_CNT_EN : when defined, adds the stallCnt output. stallCnt is a
//                     16-bit saturating count of the cycles with stall=1.
//                     When undefined, the port and its logic do not exist.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   instr[15:0]                 [15:12] opcode, [11:8] op1, [7:4] op2, [7:0] imm8
//   instrValid, flush           slot qualifiers (see above)
//   wbEn, wbAddr, wbData        write-back port from WB
//   exMemRead, exRd             load currently in EX and its destination
//   readDataOp1/2               register read data for op1/op2
//   concatZero, signExtImd      extended immediates
//   IdExOp1, IdExOp2            source register numbers
//   wb, mem, ex                 decoded controls (bubble-forced when needed)
//   stall                       hold PC and IF/ID this cycle
//   stallCnt                    stall counter (ID_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instrValid,
    input  logic        flush,
    input  logic        wbEn,
    input  logic [3:0]  wbAddr,
    input  logic [15:0] wbData,
    input  logic        exMemRead,
    input  logic [3:0]  exRd,
    output logic [15:0] readDataOp1,
    output logic [15:0] readDataOp2,
    output logic [15:0] concatZero,
    output logic [15:0] signExtImd,
    output logic [3:0]  IdExOp1,
    output logic [3:0]  IdExOp2,
    output logic        wb,
    output logic        mem,
    output logic [1:0]  ex,
    output logic        stall
`ifdef ID_STALL_CNT_EN
    ,
    output logic [15:0] stallCnt
`endif
);

    logic [3:0]  opcode;
    logic [7:0]  imm8;
    logic [15:0] regs [16];
    logic        wbFire;

    logic        decWb;
    logic        decMem;
    logic [1:0]  decEx;
    logic        decReal;
    logic        hazard;
    logic        bubble;

    assign opcode  = instr[15:12];
    assign IdExOp1 = instr[11:8];
    assign IdExOp2 = instr[7:4];
    assign imm8    = instr[7:0];

    assign concatZero = {8'h00, imm8};
    assign signExtImd = {{8{imm8[7]}}, imm8};

    // Writes to R0 are discarded, and nothing is written while reset is held.
    assign wbFire = wbEn && (wbAddr != 4'd0) && !rst;

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (wbFire) begin
            regs[wbAddr] <= wbData;
        end
    end

    // R0 is hardwired to zero. A same-cycle write to the address being read
    // is forwarded, so WB and ID can share a cycle without a split clock.
    always_comb begin
        readDataOp1 = 16'h0000;
        if (IdExOp1 != 4'd0) begin
            readDataOp1 = (wbFire && wbAddr == IdExOp1) ? wbData : regs[IdExOp1];
        end
    end

    always_comb begin
        readDataOp2 = 16'h0000;
        if (IdExOp2 != 4'd0) begin
            readDataOp2 = (wbFire && wbAddr == IdExOp2) ? wbData : regs[IdExOp2];
        end
    end

    // ---------------------------------------------------------------------
    // Opcode decode
    // ---------------------------------------------------------------------
    always_comb begin
        decWb   = 1'b0;
        decMem  = 1'b0;
        decEx   = 2'b00;
        decReal = 1'b1;
        case (opcode)
            4'h0: begin decWb = 1'b1; decEx = 2'b00; end  // ADD
            4'h1: begin decWb = 1'b1; decEx = 2'b01; end  // SUB
            4'h2: begin decWb = 1'b1; decEx = 2'b10; end  // AND
            4'h3: begin decWb = 1'b1; decEx = 2'b11; end  // OR
            4'h4: begin decWb = 1'b1; decEx = 2'b00; end  // ADDI
            4'h8: begin decWb = 1'b1; decMem = 1'b1; end  // LW
            4'h9: begin decMem = 1'b1; end                // SW
            default: decReal = 1'b0;                      // NOP
        endcase
    end

    // A load in EX produces its value too late for the instruction in ID to
    // use it, so the dependent instruction must wait one cycle. Both source
    // fields are compared for every opcode; for ADDI this is conservative.
    assign hazard = instrValid && decReal && exMemRead && (exRd != 4'd0) &&
                    ((exRd == IdExOp1) || (exRd == IdExOp2));

    assign stall  = !rst && !flush && hazard;
    assign bubble = rst || flush || !instrValid || hazard;

    assign wb  = bubble ? 1'b0  : decWb;
    assign mem = bubble ? 1'b0  : decMem;
    assign ex  = bubble ? 2'b00 : decEx;

`ifdef ID_STALL_CNT_EN
    // The counter saturates rather than wrapping, so a long stall cannot
    // make it look as if few stalls occurred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= 16'h0000;
        end else if (stall && stallCnt != 16'hFFFF) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        instrValid;
    logic        flush;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [15:0] wbData;
    logic        exMemRead;
    logic [3:0]  exRd;
    logic [15:0] readDataOp1;
    logic [15:0] readDataOp2;
    logic [15:0] concatZero;
    logic [15:0] signExtImd;
    logic [3:0]  IdExOp1;
    logic [3:0]  IdExOp2;
    logic        wb;
    logic        mem;
    logic [1:0]  ex;
    logic        stall;
`ifdef ID_STALL_CNT_EN
    logic [15:0] stallCnt;
`endif

    int checks   = 0;
    int failures = 0;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instrValid  (instrValid),
        .flush       (flush),
        .wbEn        (wbEn),
        .wbAddr      (wbAddr),
        .wbData      (wbData),
        .exMemRead   (exMemRead),
        .exRd        (exRd),
        .readDataOp1 (readDataOp1),
        .readDataOp2 (readDataOp2),
        .concatZero  (concatZero),
        .signExtImd  (signExtImd),
        .IdExOp1     (IdExOp1),
        .IdExOp2     (IdExOp2),
        .wb          (wb),
        .mem         (mem),
        .ex          (ex),
        .stall       (stall)
`ifdef ID_STALL_CNT_EN
        ,
        .stallCnt    (stallCnt)
`endif
    );

    // ---------------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic f,
                         input logic mr, input logic [3:0] rd);
        instr      = i;
        instrValid = v;
        flush      = f;
        exMemRead  = mr;
        exRd       = rd;
    endtask

    // One write through the WB port, clocked in on the next rising edge.
    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wbEn = 1'b1; wbAddr = a; wbData = d;
        @(posedge clk);
        @(negedge clk);
        wbEn = 1'b0; wbAddr = 4'd0; wbData = 16'h0000;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        flush;
        logic        exMemRead;
        logic [3:0]  exRd;
        logic        expWb;
        logic        expMem;
        logic [1:0]  expEx;
        logic        expStall;
        logic [15:0] expZero;
        logic [15:0] expSign;
    } vec_t;

    vec_t vecs [19];

    initial begin
        // instr, valid, flush, exMemRead, exRd | wb, mem, ex, stall, concatZero, signExtImd
        vecs[0]  = '{16'h0340, 1, 0, 0, 4'd0, 1, 0, 2'd0, 0, 16'h0040, 16'h0040}; // ADD
        vecs[1]  = '{16'h1340, 1, 0, 0, 4'd0, 1, 0, 2'd1, 0, 16'h0040, 16'h0040}; // SUB
        vecs[2]  = '{16'h2340, 1, 0, 0, 4'd0, 1, 0, 2'd2, 0, 16'h0040, 16'h0040}; // AND
        vecs[3]  = '{16'h3340, 1, 0, 0, 4'd0, 1, 0, 2'd3, 0, 16'h0040, 16'h0040}; // OR
        vecs[4]  = '{16'h4A85, 1, 0, 0, 4'd0, 1, 0, 2'd0, 0, 16'h0085, 16'hFF85}; // ADDI
        vecs[5]  = '{16'h81F0, 1, 0, 0, 4'd0, 1, 1, 2'd0, 0, 16'h00F0, 16'hFFF0}; // LW
        vecs[6]  = '{16'h927F, 1, 0, 0, 4'd0, 0, 1, 2'd0, 0, 16'h007F, 16'h007F}; // SW
        vecs[7]  = '{16'h5123, 1, 0, 0, 4'd0, 0, 0, 2'd0, 0, 16'h0023, 16'h0023}; // NOP 5
        vecs[8]  = '{16'hF000, 1, 0, 0, 4'd0, 0, 0, 2'd0, 0, 16'h0000, 16'h0000}; // NOP F
        vecs[9]  = '{16'h0340, 0, 0, 0, 4'd0, 0, 0, 2'd0, 0, 16'h0040, 16'h0040}; // invalid
        vecs[10] = '{16'h3340, 1, 1, 0, 4'd0, 0, 0, 2'd0, 0, 16'h0040, 16'h0040}; // flush
        vecs[11] = '{16'h0230, 1, 0, 1, 4'd2, 0, 0, 2'd0, 1, 16'h0030, 16'h0030}; // hazard op1
        vecs[12] = '{16'h1320, 1, 0, 1, 4'd2, 0, 0, 2'd0, 1, 16'h0020, 16'h0020}; // hazard op2
        vecs[13] = '{16'h0000, 1, 0, 1, 4'd0, 1, 0, 2'd0, 0, 16'h0000, 16'h0000}; // exRd=0
        vecs[14] = '{16'h0230, 1, 1, 1, 4'd2, 0, 0, 2'd0, 0, 16'h0030, 16'h0030}; // hazard+flush
        vecs[15] = '{16'h6200, 1, 0, 1, 4'd2, 0, 0, 2'd0, 0, 16'h0000, 16'h0000}; // NOP no hazard
        vecs[16] = '{16'h0230, 0, 0, 1, 4'd2, 0, 0, 2'd0, 0, 16'h0030, 16'h0030}; // invalid no hazard
        vecs[17] = '{16'h0230, 1, 0, 0, 4'd2, 1, 0, 2'd0, 0, 16'h0030, 16'h0030}; // no load
        vecs[18] = '{16'h8230, 1, 0, 1, 4'd5, 1, 1, 2'd0, 0, 16'h0030, 16'h0030}; // other reg
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        wbEn = 1'b0; wbAddr = 4'd0; wbData = 16'h0000;
        drive(16'h0230, 1'b1, 1'b0, 1'b1, 4'd2);

        // Reset state: a hazard-forming instruction must still yield zeros.
        #2;
        check("rst_wb", {31'd0, wb}, 32'd0);
        check("rst_mem", {31'd0, mem}, 32'd0);
        check("rst_ex", {30'd0, ex}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
`ifdef ID_STALL_CNT_EN
        check("rst_cnt", {16'd0, stallCnt}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

        // Write R3, then decode ADD R3,R4.
        write_reg(4'd3, 16'h1234);
        drive(16'h0340, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        check("r3_read", {16'd0, readDataOp1}, 32'h1234);
        check("r4_read", {16'd0, readDataOp2}, 32'h0000);
        check("add_wb", {31'd0, wb}, 32'd1);
        check("add_ex", {30'd0, ex}, 32'd0);
        check("op1_num", {28'd0, IdExOp1}, 32'd3);
        check("op2_num", {28'd0, IdExOp2}, 32'd4);

        // Same-cycle bypass on op1, then the stored value after the edge.
        @(negedge clk);
        wbEn = 1'b1; wbAddr = 4'd5; wbData = 16'hBEEF;
        drive(16'h0560, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        check("bypass_op1", {16'd0, readDataOp1}, 32'hBEEF);
        check("bypass_op2", {16'd0, readDataOp2}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        wbEn = 1'b0;
        #1;
        check("r5_stored", {16'd0, readDataOp1}, 32'hBEEF);

        // Bypass on op2.
        @(negedge clk);
        wbEn = 1'b1; wbAddr = 4'd6; wbData = 16'h5A5A;
        #1;
        check("bypass_op2b", {16'd0, readDataOp2}, 32'h5A5A);
        @(posedge clk);
        @(negedge clk);
        wbEn = 1'b0;

        // Writes to R0 are ignored, both bypassed and stored.
        @(negedge clk);
        wbEn = 1'b1; wbAddr = 4'd0; wbData = 16'hFFFF;
        drive(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        check("r0_bypass", {16'd0, readDataOp1}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        wbEn = 1'b0;
        #1;
        check("r0_stored", {16'd0, readDataOp1}, 32'h0000);

        // Table-driven decode / hazard vectors.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].valid, vecs[i].flush, vecs[i].exMemRead, vecs[i].exRd);
            #1;
            check($sformatf("v%0d_wb", i), {31'd0, wb}, {31'd0, vecs[i].expWb});
            check($sformatf("v%0d_mem", i), {31'd0, mem}, {31'd0, vecs[i].expMem});
            check($sformatf("v%0d_ex", i), {30'd0, ex}, {30'd0, vecs[i].expEx});
            check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].expStall});
            check($sformatf("v%0d_zext", i), {16'd0, concatZero}, {16'd0, vecs[i].expZero});
            check($sformatf("v%0d_sext", i), {16'd0, signExtImd}, {16'd0, vecs[i].expSign});
        end

        // Load-use stall, then the load leaves EX and decode resumes.
        @(negedge clk);
        drive(16'h0230, 1'b1, 1'b0, 1'b1, 4'd2);
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_wb", {31'd0, wb}, 32'd0);
        @(negedge clk);
        exMemRead = 1'b0;
        #1;
        check("lu_release_stall", {31'd0, stall}, 32'd0);
        check("lu_release_wb", {31'd0, wb}, 32'd1);

        // Asynchronous reset mid-operation: R3 and R5 hold data beforehand.
        @(negedge clk);
        drive(16'h0350, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        check("pre_rst_r3", {16'd0, readDataOp1}, 32'h1234);
        #1;
        rst = 1'b1;
        #1;
        check("async_r3", {16'd0, readDataOp1}, 32'h0000);
        check("async_r5", {16'd0, readDataOp2}, 32'h0000);
        check("async_wb", {31'd0, wb}, 32'd0);

        // A write presented while reset is held across an edge is dropped.
        @(negedge clk);
        wbEn = 1'b1; wbAddr = 4'd7; wbData = 16'hAAAA;
        drive(16'h0700, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        check("rst_bypass", {16'd0, readDataOp1}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wbEn = 1'b0;
        #1;
        check("rst_write_dropped", {16'd0, readDataOp1}, 32'h0000);

`ifdef ID_STALL_CNT_EN
        // Three stall cycles.
        check("cnt_zero", {16'd0, stallCnt}, 32'd0);
        @(negedge clk);
        drive(16'h0230, 1'b1, 1'b0, 1'b1, 4'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(16'h0230, 1'b1, 1'b1, 1'b1, 4'd2);  // flush masks the hazard
        #1;
        check("cnt_three", {16'd0, stallCnt}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("cnt_flush_hold", {16'd0, stallCnt}, 32'd3);

        // Run well past 16'hFFFF stalls and confirm saturation.
        flush = 1'b0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("cnt_sat", {16'd0, stallCnt}, 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check("cnt_sat_hold", {16'd0, stallCnt}, 32'hFFFF);
        rst = 1'b1;
        #1;
        check("cnt_rst", {16'd0, stallCnt}, 32'd0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
